// File: rtl/axi_slave_mem.sv
// axi_slave_mem
// Memory-backed AXI-style responder. Write bursts (AW/W/B) are stored into
// an internal word array. Read bursts (AR/R) of fixed length RD_LEN+1 are
// returned from the same array. The write and read state machines are
// independent and can run at the same time.
//
// Build option: AXI_SLAVE_ERR_RESP_EN
//   defined   - out-of-range, size and beat-count checks are active and
//               failing bursts/beats report SLVERR (2'b10)
//   undefined - no checks; the word index wraps modulo MEM_DEPTH and
//               BRESP_o/RRESP_o are always 2'b00
//
// Ports
//   ACLK_i, ARESETn_i            clock, synchronous active-low reset
//   AW*_i / AWREADY_o            write address channel
//   W*_i / WREADY_o              write data channel
//   BVALID_o/BRESP_o/BID_o, BREADY_i   write response channel
//   AR*_i / ARREADY_o            read address channel
//   R*_o / RREADY_i              read data channel
//
// state  | meaning
// W_IDLE | waiting for a write address (AWREADY_o when ready_en)
// W_DATA | accepting write beats (WREADY_o)
// W_RESP | holding the write response until BREADY_i
// R_IDLE | waiting for a read address (ARREADY_o when ready_en)
// R_DATA | presenting read beats until the RLAST_o handshake

module axi_slave_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int RD_LEN    = 3,
    parameter int RDATA_W   = 128
) (
    input  logic               ACLK_i,
    input  logic               ARESETn_i,
    input  logic [31:0]        AWADDR_i,
    input  logic               AWVALID_i,
    input  logic [3:0]         AWID_i,
    output logic               AWREADY_o,
    input  logic [31:0]        WDATA_i,
    input  logic               WVALID_i,
    input  logic [3:0]         WLEN_i,
    input  logic               WLAST_i,
    input  logic [2:0]         WSIZE_i,
    output logic               WREADY_o,
    output logic               BVALID_o,
    output logic [1:0]         BRESP_o,
    output logic [3:0]         BID_o,
    input  logic               BREADY_i,
    input  logic [31:0]        ARADDR_i,
    input  logic               ARVALID_i,
    input  logic [3:0]         ARID_i,
    output logic               ARREADY_o,
    output logic [RDATA_W-1:0] RDATA_o,
    output logic               RVALID_o,
    output logic [1:0]         RRESP_o,
    output logic [3:0]         RLEN_o,
    output logic [2:0]         RSIZE_o,
    output logic               RLAST_o,
    output logic [3:0]         RID_o,
    input  logic               RREADY_i
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        ready_en;

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0] w_addr;
    logic [3:0]  w_id;
    logic        aw_hs, w_hs, w_beat_ok;

    logic [31:0] r_addr, rd_addr, rd_word;
    logic [31:0] rdata_q;
    logic [3:0]  r_id, r_left;
    logic        rlast_q;
    logic        ar_hs, r_hs;

    assign AWREADY_o = (w_state == W_IDLE) && ready_en;
    assign ARREADY_o = (r_state == R_IDLE) && ready_en;
    assign WREADY_o  = (w_state == W_DATA);
    assign BVALID_o  = (w_state == W_RESP);
    assign BID_o     = w_id;
    assign RVALID_o  = (r_state == R_DATA);
    assign RDATA_o   = RDATA_W'(rdata_q);
    assign RLAST_o   = rlast_q;
    assign RID_o     = r_id;
    // Fixed burst descriptors are only driven while a beat is presented so
    // that the channel reads all-zero out of reset.
    assign RLEN_o    = RVALID_o ? 4'(RD_LEN) : 4'd0;
    assign RSIZE_o   = RVALID_o ? 3'b010 : 3'b000;

    assign aw_hs   = AWVALID_i && AWREADY_o;
    assign w_hs    = (w_state == W_DATA) && WVALID_i;
    assign ar_hs   = ARVALID_i && ARREADY_o;
    assign r_hs    = (r_state == R_DATA) && RREADY_i;

    // Address for the next read beat to load: the AR address on accept,
    // otherwise the running burst address.
    assign rd_addr = ar_hs ? ARADDR_i : r_addr;

`ifdef AXI_SLAVE_ERR_RESP_EN
    logic [3:0]  w_cnt, w_len, w_len_eff;
    logic        w_err, w_cnt_bad, rd_ok;
    logic [1:0]  rresp_q;
    logic [1:0]  unused_addr_bits;

    assign w_beat_ok = ({2'b00, w_addr[31:2]} < 32'(MEM_DEPTH)) && (WSIZE_i == 3'b010);
    // WLEN_i is only meaningful on the first beat; later beats use the copy.
    assign w_len_eff = (w_cnt == 4'd0) ? WLEN_i : w_len;
    assign w_cnt_bad = WLAST_i && (w_cnt != w_len_eff);
    assign rd_ok     = ({2'b00, rd_addr[31:2]} < 32'(MEM_DEPTH));
    assign rd_word   = rd_ok ? mem[rd_addr[IDX_W+1:2]] : 32'd0;
    assign BRESP_o   = (BVALID_o && w_err) ? 2'b10 : 2'b00;
    assign RRESP_o   = rresp_q;
    assign unused_addr_bits = {^w_addr[1:0], ^rd_addr[1:0]};
`else
    logic        unused_addr_bits;

    assign w_beat_ok = 1'b1;
    assign rd_word   = mem[rd_addr[IDX_W+1:2]];
    assign BRESP_o   = 2'b00;
    assign RRESP_o   = 2'b00;
    assign unused_addr_bits = ^{w_addr[31:IDX_W+2], w_addr[1:0],
                                rd_addr[31:IDX_W+2], rd_addr[1:0], WSIZE_i, WLEN_i};
`endif

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)            w_next = W_DATA;
            W_DATA:  if (w_hs && WLAST_i)  w_next = W_RESP;
            W_RESP:  if (BREADY_i)         w_next = W_IDLE;
            default:                       w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)            r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q)  r_next = R_IDLE;
            default:                       r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            w_addr <= 32'd0;
            w_id   <= 4'd0;
`ifdef AXI_SLAVE_ERR_RESP_EN
            w_cnt  <= 4'd0;
            w_len  <= 4'd0;
            w_err  <= 1'b0;
`endif
        end else if (aw_hs) begin
            w_addr <= AWADDR_i;
            w_id   <= AWID_i;
`ifdef AXI_SLAVE_ERR_RESP_EN
            w_cnt  <= 4'd0;
            w_err  <= 1'b0;
`endif
        end else if (w_hs) begin
            w_addr <= w_addr + 32'd4;
`ifdef AXI_SLAVE_ERR_RESP_EN
            w_cnt  <= w_cnt + 4'd1;
            if (w_cnt == 4'd0) w_len <= WLEN_i;
            if (!w_beat_ok || w_cnt_bad) w_err <= 1'b1;
`endif
        end
    end

    // Storage is deliberately not reset; a beat presented in a reset cycle
    // is dropped so only beats accepted before reset survive.
    always_ff @(posedge ACLK_i) begin
        if (ARESETn_i && w_hs && w_beat_ok)
            mem[w_addr[IDX_W+1:2]] <= WDATA_i;
    end

    // r_left counts the beats still to be loaded after the current one;
    // the beat loaded when it reaches zero is the last.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            r_addr  <= 32'd0;
            r_id    <= 4'd0;
            r_left  <= 4'd0;
            rlast_q <= 1'b0;
            rdata_q <= 32'd0;
`ifdef AXI_SLAVE_ERR_RESP_EN
            rresp_q <= 2'b00;
`endif
        end else if (ar_hs) begin
            r_id    <= ARID_i;
            r_left  <= 4'(RD_LEN);
            rlast_q <= (RD_LEN == 0);
            r_addr  <= rd_addr + 32'd4;
            rdata_q <= rd_word;
`ifdef AXI_SLAVE_ERR_RESP_EN
            rresp_q <= rd_ok ? 2'b00 : 2'b10;
`endif
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                r_left  <= r_left - 4'd1;
                rlast_q <= (r_left == 4'd1);
                r_addr  <= rd_addr + 32'd4;
                rdata_q <= rd_word;
`ifdef AXI_SLAVE_ERR_RESP_EN
                rresp_q <= rd_ok ? 2'b00 : 2'b10;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

    localparam int MEM_DEPTH = 256;
    localparam int RD_LEN    = 3;
    localparam int RDATA_W   = 128;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic [31:0]        awaddr;
    logic               awvalid;
    logic [3:0]         awid;
    logic               awready;
    logic [31:0]        wdata;
    logic               wvalid;
    logic [3:0]         wlen;
    logic               wlast;
    logic [2:0]         wsize;
    logic               wready;
    logic               bvalid;
    logic [1:0]         bresp;
    logic [3:0]         bid;
    logic               bready;
    logic [31:0]        araddr;
    logic               arvalid;
    logic [3:0]         arid;
    logic               arready;
    logic [RDATA_W-1:0] rdata;
    logic               rvalid;
    logic [1:0]         rresp;
    logic [3:0]         rlen;
    logic [2:0]         rsize;
    logic               rlast;
    logic [3:0]         rid;
    logic               rready;

    axi_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .RD_LEN(RD_LEN), .RDATA_W(RDATA_W)) dut (
        .ACLK_i(aclk), .ARESETn_i(aresetn),
        .AWADDR_i(awaddr), .AWVALID_i(awvalid), .AWID_i(awid), .AWREADY_o(awready),
        .WDATA_i(wdata), .WVALID_i(wvalid), .WLEN_i(wlen), .WLAST_i(wlast),
        .WSIZE_i(wsize), .WREADY_o(wready),
        .BVALID_o(bvalid), .BRESP_o(bresp), .BID_o(bid), .BREADY_i(bready),
        .ARADDR_i(araddr), .ARVALID_i(arvalid), .ARID_i(arid), .ARREADY_o(arready),
        .RDATA_o(rdata), .RVALID_o(rvalid), .RRESP_o(rresp), .RLEN_o(rlen),
        .RSIZE_o(rsize), .RLAST_o(rlast), .RID_o(rid), .RREADY_i(rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] d; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bresp_t;

    logic [31:0] mmem [MEM_DEPTH];
    rbeat_t      rq[$];
    bresp_t      bq[$];
    logic [3:0]  r_id_m;
    bit          w_act = 0;
    logic [31:0] w_addr_m;
    logic [3:0]  w_id_m;
    int          w_beats_m, w_len_m;
    bit          w_err_m;
    bit          mon_en = 0;
    logic        rst_q = 1'b0;

    function automatic bit m_ok(input logic [31:0] a);
`ifdef AXI_SLAVE_ERR_RESP_EN
        return (a >> 2) < MEM_DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % MEM_DEPTH);
    endfunction

    always @(posedge aclk) rst_q <= aresetn;

    always @(negedge aclk) begin
        if (mon_en) begin
            chk("wready", wready, w_act);
            chk("bvalid", bvalid, bq.size() != 0);
            chk("rvalid", rvalid, rq.size() != 0);
            chk("awready", awready, rst_q && !w_act && bq.size() == 0);
            chk("arready", arready, rst_q && rq.size() == 0);
            if (!rst_q) begin
                chk("rst_bresp", bresp, 0);
                chk("rst_bid", bid, 0);
                chk("rst_rdata", rdata, 0);
                chk("rst_rresp", rresp, 0);
                chk("rst_rlen", rlen, 0);
                chk("rst_rsize", rsize, 0);
                chk("rst_rlast", rlast, 0);
                chk("rst_rid", rid, 0);
            end
            if (rvalid && rq.size() != 0) begin
                chk("rdata", rdata, {96'd0, rq[0].d});
                chk("rresp", rresp, rq[0].resp);
                chk("rlast", rlast, rq[0].last);
                chk("rid", rid, r_id_m);
                chk("rlen", rlen, RD_LEN);
                chk("rsize", rsize, 3'b010);
            end
            if (bvalid && bq.size() != 0) begin
                chk("bid", bid, bq[0].id);
                chk("bresp", bresp, bq[0].resp);
            end
            if (!aresetn) begin
                rq.delete();
                bq.delete();
                w_act = 0;
            end else begin
                if (arvalid && arready) begin
                    r_id_m = arid;
                    for (int b = 0; b <= RD_LEN; b++) begin
                        logic [31:0] a;
                        rbeat_t e;
                        a = araddr + 32'(4 * b);
                        e.d    = m_ok(a) ? mmem[m_idx(a)] : 32'd0;
                        e.resp = m_ok(a) ? 2'b00 : 2'b10;
                        e.last = (b == RD_LEN);
                        rq.push_back(e);
                    end
                end
                if (rvalid && rready && rq.size() != 0) void'(rq.pop_front());
                if (bvalid && bready && bq.size() != 0) void'(bq.pop_front());
                if (awvalid && awready) begin
                    w_act = 1; w_addr_m = awaddr; w_id_m = awid;
                    w_beats_m = 0; w_err_m = 0;
                end
                if (wvalid && wready && w_act) begin
                    logic [31:0] a;
                    bit bad;
                    a = w_addr_m + 32'(4 * w_beats_m);
                    if (w_beats_m == 0) w_len_m = int'(wlen);
`ifdef AXI_SLAVE_ERR_RESP_EN
                    bad = (wsize != 3'b010) || !m_ok(a);
`else
                    bad = 0;
`endif
                    if (!bad) mmem[m_idx(a)] = wdata;
                    w_err_m = w_err_m || bad;
                    w_beats_m++;
                    if (wlast) begin
                        bresp_t e;
`ifdef AXI_SLAVE_ERR_RESP_EN
                        if (w_beats_m != w_len_m + 1) w_err_m = 1;
`endif
                        e.id = w_id_m;
                        e.resp = w_err_m ? 2'b10 : 2'b00;
                        bq.push_back(e);
                        w_act = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] rd_buf  [16];
    logic [1:0]  rd_rsp  [16];
    int          rd_n;

    task automatic do_aw(input logic [31:0] a, input logic [3:0] id);
        bit ok;
        ok = 0;
        awaddr = a; awid = id; awvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1; break; end
        end
        chk("aw_accept", ok, 1);
        @(posedge aclk); #1;
        awvalid = 0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] len, input logic last,
                        input logic [2:0] size);
        bit ok;
        ok = 0;
        wdata = d; wlen = len; wlast = last; wsize = size; wvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (wready) begin ok = 1; break; end
        end
        chk("w_accept", ok, 1);
        @(posedge aclk); #1;
        wvalid = 0; wlast = 0;
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                            input int nbeats, input logic [31:0] base, input logic [2:0] size);
        do_aw(a, id);
        for (int b = 0; b < nbeats; b++)
            do_w(base + 32'(b), len, b == nbeats - 1, size);
    endtask

    task automatic wait_b(output logic [3:0] id_o, output logic [1:0] resp_o);
        bit ok;
        ok = 0; id_o = 'x; resp_o = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bvalid && bready) begin ok = 1; id_o = bid; resp_o = bresp; break; end
        end
        chk("b_seen", ok, 1);
        @(posedge aclk); #1;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id);
        bit ok;
        ok = 0;
        araddr = a; arid = id; arvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1; break; end
        end
        chk("ar_accept", ok, 1);
        @(posedge aclk); #1;
        arvalid = 0;
    endtask

    task automatic rd_collect();
        bit done;
        done = 0;
        rready = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge aclk);
            if (rvalid && rready) begin
                if (rd_n < 16) begin
                    rd_buf[rd_n] = rdata[31:0];
                    rd_rsp[rd_n] = rresp;
                end
                rd_n++;
                if (rlast) done = 1;
            end
        end
        chk("rd_beats", rd_n, RD_LEN + 1);
        @(posedge aclk); #1;
        rready = 0;
    endtask

    task automatic do_rd(input logic [31:0] a, input logic [3:0] id);
        do_ar(a, id);
        rd_n = 0;
        rd_collect();
    endtask

    // ---------------- directed sequence ----------------
    logic [3:0] got_id;
    logic [1:0] got_resp;

    initial begin
        aresetn = 0; awaddr = 0; awvalid = 0; awid = 0;
        wdata = 0; wvalid = 0; wlen = 0; wlast = 0; wsize = 3'b010;
        bready = 1; araddr = 0; arvalid = 0; arid = 0; rready = 0;

        repeat (2) @(posedge aclk);
        #1 mon_en = 1;
        @(negedge aclk);
        chk("reset_awready", awready, 0);
        chk("reset_arready", arready, 0);
        chk("reset_bvalid", bvalid, 0);
        @(posedge aclk); #1 aresetn = 1;
        @(negedge aclk);
        chk("release_awready_0", awready, 0);
        @(negedge aclk);
        chk("release_awready_1", awready, 1);
        @(posedge aclk); #1;

        // Preload words 0..31 with 0x1000+index.
        wr_burst(32'h0, 4'd1, 4'd15, 16, 32'h1000, 3'b010);
        wait_b(got_id, got_resp);
        wr_burst(32'h40, 4'd1, 4'd15, 16, 32'h1010, 3'b010);
        wait_b(got_id, got_resp);

        // Basic write then read.
        wr_burst(32'h10, 4'd4, 4'd3, 4, 32'hA0, 3'b010);
        wait_b(got_id, got_resp);
        chk("wr_bid", got_id, 4'd4);
        chk("wr_bresp", got_resp, 2'b00);
        do_rd(32'h10, 4'd2);
        chk("rd_beat0", rd_buf[0], 32'hA0);
        chk("rd_beat3", rd_buf[3], 32'hA3);

        // R backpressure on beat 1.
        do_ar(32'h10, 4'd7);
        rready = 1;
        @(negedge aclk);
        chk("bp_beat0", rdata[31:0], 32'hA0);
        @(posedge aclk); #1 rready = 0;
        repeat (5) begin
            @(negedge aclk);
            chk("bp_hold_valid", rvalid, 1);
            chk("bp_hold_data", rdata[31:0], 32'hA1);
        end
        @(posedge aclk); #1;
        rd_n = 1;
        rd_collect();
        chk("bp_beat3", rd_buf[3], 32'hA3);

        // B backpressure.
        bready = 0;
        wr_burst(32'h50, 4'd5, 4'd0, 1, 32'hC5, 3'b010);
        repeat (3) begin
            @(negedge aclk);
            chk("bhold_valid", bvalid, 1);
            chk("bhold_id", bid, 4'd5);
        end
        @(posedge aclk); #1 bready = 1;
        wait_b(got_id, got_resp);
        chk("bhold_resp", got_resp, 2'b00);

`ifdef AXI_SLAVE_ERR_RESP_EN
        wr_burst(32'((MEM_DEPTH - 2) * 4), 4'd2, 4'd3, 4, 32'hB0, 3'b010);
        wait_b(got_id, got_resp);
        chk("oor_bresp", got_resp, 2'b10);
        do_rd(32'((MEM_DEPTH - 2) * 4), 4'd3);
        chk("oor_rd0", rd_buf[0], 32'hB0);
        chk("oor_rd2", rd_buf[2], 32'h0);
        chk("oor_rresp2", rd_rsp[2], 2'b10);
        wr_burst(32'h60, 4'd3, 4'd0, 1, 32'hE1, 3'b001);
        wait_b(got_id, got_resp);
        chk("size_bresp", got_resp, 2'b10);
        wr_burst(32'h60, 4'd3, 4'd3, 2, 32'hE2, 3'b010);
        wait_b(got_id, got_resp);
        chk("short_bresp", got_resp, 2'b10);
        wr_burst(32'h60, 4'd3, 4'd0, 1, 32'hE4, 3'b010);
        wait_b(got_id, got_resp);
        chk("ok_after_err_bresp", got_resp, 2'b00);
`else
        wr_burst(32'((MEM_DEPTH - 2) * 4), 4'd2, 4'd3, 4, 32'hB0, 3'b010);
        wait_b(got_id, got_resp);
        chk("wrap_bresp", got_resp, 2'b00);
        do_rd(32'h0, 4'd3);
        chk("wrap_rd0", rd_buf[0], 32'hB2);
        chk("wrap_rd1", rd_buf[1], 32'hB3);
        chk("wrap_rd2", rd_buf[2], 32'h1002);
        wr_burst(32'h60, 4'd3, 4'd0, 1, 32'hE1, 3'b001);
        wait_b(got_id, got_resp);
        chk("nochk_size_bresp", got_resp, 2'b00);
        do_rd(32'h60, 4'd3);
        chk("nochk_size_data", rd_buf[0], 32'hE1);
`endif

        // Concurrent write and read to different words.
        fork
            begin
                logic [3:0] cid;
                logic [1:0] cresp;
                wr_burst(32'h100, 4'd3, 4'd3, 4, 32'hC0, 3'b010);
                wait_b(cid, cresp);
                chk("conc_bresp", cresp, 2'b00);
            end
            do_rd(32'h10, 4'd1);
        join
        chk("conc_rd0", rd_buf[0], 32'hA0);

        // Same-cycle write and read-load of word 8: read sees the old data.
        do_aw(32'h20, 4'd6);
        wdata = 32'hD0; wlen = 0; wlast = 1; wsize = 3'b010; wvalid = 1;
        araddr = 32'h20; arid = 4'd8; arvalid = 1;
        @(negedge aclk);
        chk("coll_wready", wready, 1);
        chk("coll_arready", arready, 1);
        @(posedge aclk); #1;
        wvalid = 0; wlast = 0; arvalid = 0;
        rd_n = 0;
        rd_collect();
        chk("coll_old", rd_buf[0], 32'h1008);
        do_rd(32'h20, 4'd8);
        chk("coll_new", rd_buf[0], 32'hD0);

        // Reset during beat 2 of a write.
        do_aw(32'h30, 4'd9);
        do_w(32'hF0, 4'd3, 1'b0, 3'b010);
        wdata = 32'hF1; wvalid = 1; aresetn = 0;
        @(posedge aclk); #1;
        wvalid = 0;
        @(negedge aclk);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        @(posedge aclk); #1 aresetn = 1;
        @(negedge aclk);
        chk("mid_rel_awready_0", awready, 0);
        @(negedge aclk);
        chk("mid_rel_awready_1", awready, 1);
        @(posedge aclk); #1;
        do_rd(32'h30, 4'd1);
        chk("mid_rst_beat1_kept", rd_buf[0], 32'hF0);
        chk("mid_rst_beat2_dropped", rd_buf[1], 32'h100D);

        repeat (3) @(posedge aclk);
        chk("r_queue_drained", rq.size(), 0);
        chk("b_queue_drained", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI-style memory-backed slave: the responder end of the block that drives AW/W/B/AR/R as initiator. It accepts write bursts into an internal word array and returns fixed-length read bursts from it, with independent write and read state machines. It sits on the on-chip interconnect opposite the master and serves as the bring-up and verification target for it.

## Interface
- MEM_DEPTH, 256: number of 32-bit words; power of two.
- RD_LEN, 3: read burst length minus one, driven on RLEN_o.
- RDATA_W, 128: RDATA_o width; the read word sits in [31:0], upper bits are 0.
- ACLK_i  in  1  clock, rising edge.
- ARESETn_i  in  1  reset; synchronous, active-low.
- AWADDR_i / AWVALID_i / AWID_i  in  32/1/4  write address channel.
- AWREADY_o  out  1  write address accept.
- WDATA_i / WVALID_i / WLEN_i / WLAST_i / WSIZE_i  in  32/1/4/1/3  write data, beat count minus one, last flag, size.
- WREADY_o  out  1  write data accept.
- BVALID_o / BRESP_o / BID_o  out  1/2/4  write response.
- BREADY_i  in  1  response accept.
- ARADDR_i / ARVALID_i / ARID_i  in  32/1/4  read address channel.
- ARREADY_o  out  1  read address accept.
- RDATA_o / RVALID_o / RRESP_o / RLEN_o / RSIZE_o / RLAST_o / RID_o  out  RDATA_W/1/2/4/3/1/4  read data channel.
- RREADY_i  in  1  read data accept.

## Operation
- Word index = addr[31:2]. The address is in range when the index is < MEM_DEPTH. Each beat increments the address by 4. INCR only.
- Write FSM has three states: W_IDLE -> W_DATA on AWVALID_i&AWREADY_o -> W_RESP on a W handshake with WLAST_i=1 -> W_IDLE on BVALID_o&BREADY_i.
- On the AW handshake, capture AWADDR_i and AWID_i.
- In W_DATA, each W handshake writes WDATA_i to mem[index]. WLEN_i is sampled on the first beat. The beat counter is 4 bits.
- The error flag is set on any beat where WSIZE_i != 3'b010 or the address is out of range; that beat is not written.
- The error flag is also set if the number of beats at WLAST_i is != WLEN_i+1.
- BRESP_o is 2'b10 (SLVERR) if the error flag is set, else 2'b00. BID_o = captured AWID.
- Read FSM has two states: R_IDLE -> R_DATA on ARVALID_i&ARREADY_o -> R_IDLE on a handshake where RLAST_o=1.
- On the AR handshake, capture ARADDR_i and ARID_i.
- A read burst is RD_LEN+1 beats. Fixed outputs: RLEN_o=RD_LEN, RSIZE_o=3'b010, RID_o=captured ARID.
- An out-of-range read beat returns data 0 with RRESP_o=2'b10; otherwise RRESP_o=2'b00.
- The two FSMs are independent and may be active simultaneously.

## Timing
- Every output resets to 0, including AWREADY_o and ARREADY_o.
- A ready_en flop resets to 0 and sets to 1 one cycle after ARESETn_i rises.
- AWREADY_o = (W_IDLE & ready_en); ARREADY_o = (R_IDLE & ready_en). Both are combinational, so no double accept is possible.
- WREADY_o = W_DATA, which is 1 cycle after the AW handshake. WVALID_i in W_IDLE is ignored.
- BVALID_o rises 1 cycle after the last W handshake and holds, with BRESP_o/BID_o stable, until BREADY_i.
- RVALID_o rises 1 cycle after the AR handshake with beat 0 loaded.
- RDATA_o, RRESP_o and RLAST_o are registered. They hold while RREADY_i=0 and advance one beat per handshake.
- RLAST_o is 1 only on beat RD_LEN. RVALID_o drops the cycle after the last handshake.
- Same-cycle write and read-load of the same word: the read returns the old data.
- Reset asserted mid-burst: both FSMs return to idle at that edge, partial write data already stored is kept, and no B or R beat is emitted.

## Configuration
- AXI_SLAVE_ERR_RESP_EN defined: out-of-range, size and beat-count checks are active, and SLVERR is reported as above.
- AXI_SLAVE_ERR_RESP_EN undefined: all error checks are removed, and BRESP_o and RRESP_o are always 2'b00.
  - Word index becomes addr[log2(MEM_DEPTH)+1:2], so addresses wrap modulo the memory size.
  - Every beat is written or read.

## Test plan
- Write burst: AW 0x10 ID 4, WLEN 3, data 0xA0..0xA3 with WLAST on beat 4 -> WREADY 1 cycle after AW, BVALID with BID 4, BRESP 00. Then AR 0x10 ID 2 -> RDATA 0xA0..0xA3, RLAST on the 4th beat, RID 2, RLEN 3, RSIZE 010.
- Backpressure: hold RREADY_i=0 for 5 cycles on beat 1 -> RDATA_o=0xA1 and RVALID_o=1 stay stable; BREADY_i low for 3 cycles -> BVALID_o held.
- Errors (macro defined): AW with index MEM_DEPTH-2, 4 beats -> beats 3-4 not written, BRESP 10. WSIZE 3'b001 -> BRESP 10. WLAST on beat 2 with WLEN 3 -> BRESP 10.
- Wrap (macro undefined): write 0xB0..0xB3 at index MEM_DEPTH-2 -> BRESP 00; read index 0 returns 0xB2, 0xB3.
- Concurrency: a read burst runs during a write burst to different addresses -> both complete; the read of a word written in the same cycle returns its old value.
- Reset mid-burst: ARESETn_i low during beat 2 of a write -> all outputs 0. AWREADY_o returns 1 cycle after release; beat 1 data is present in memory.
